// File: rtl/multi_req_gen.sv
// multi_req_gen: multi-channel keyed request generator with round-robin grant.
// Latency: start accepted in cycle t -> req in t+1; last ack at edge k -> done in k+1.
// Backpressure: req/req_key/req_chan hold stable until ack; one request per cycle with ack high.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a run (sampled only in IDLE)
//   chan_en       : per-channel enable mask, captured with an accepted start
//   req, req_key, req_chan : request valid, key and channel index of the grant
//   ack           : responder accepts the current request
//   busy          : high whenever not IDLE
//   done          : one-cycle pulse at the end of a run
module multi_req_gen #(
  parameter int CHANNELS = 4,
  parameter int KEY_W    = 4,
  parameter int MAX_REQS = 6,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHANNELS-1:0] chan_en,
  output logic                req,
  output logic [KEY_W-1:0]    req_key,
  output logic [CH_W-1:0]     req_chan,
  input  logic                ack,
  output logic                busy,
  output logic                done
);

  localparam int REM_W = $clog2(MAX_REQS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [KEY_W-1:0]  key       [CHANNELS];
  logic [REM_W-1:0]  remaining [CHANNELS];
  logic [REM_W-1:0]  rem_after [CHANNELS];
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   first_en;
  logic [CH_W-1:0]   next_grant;
  logic [CH_W-1:0]   cand;
  logic              next_found;
  logic              accept;
  logic              launch;

  assign accept = (state == S_RUN) && ack;
  assign launch = (state == S_IDLE) && start && (chan_en != '0);

  // Lowest enabled channel gets the first grant of a run.
  always_comb begin
    first_en = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_en[i]) first_en = CH_W'(i);
    end
  end

  // Remaining counts as they will be after the current grant is acknowledged.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rem_after[i] = remaining[i];
      if (CH_W'(i) == grant) rem_after[i] = remaining[i] - 1'b1;
    end
  end

  // Search forward from grant+1; scanning offsets downward lets the nearest
  // eligible channel win. Offset CHANNELS is the current channel itself, so it
  // is only picked when no other channel has work left.
  always_comb begin
    next_found = 1'b0;
    next_grant = '0;
    cand       = '0;
    for (int off = CHANNELS; off >= 1; off--) begin
      cand = CH_W'((int'(grant) + off) % CHANNELS);
      if (rem_after[cand] != '0) begin
        next_found = 1'b1;
        next_grant = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req_key   = '0;
    req_chan  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (chan_en == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        req      = 1'b1;
        req_key  = key[grant];
        req_chan = grant;
        busy     = 1'b1;
        if (accept && !next_found) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Keys are only cleared by reset so they carry on across runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        key[i]       <= '0;
        remaining[i] <= '0;
      end
    end else if (launch) begin
      grant <= first_en;
      for (int i = 0; i < CHANNELS; i++) begin
        remaining[i] <= chan_en[i] ? REM_W'(MAX_REQS) : '0;
      end
    end else if (accept) begin
      key[grant] <= key[grant] + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        remaining[i] <= rem_after[i];
      end
      if (next_found) grant <= next_grant;
    end
  end

endmodule

// File: tb/tb_multi_req_gen.sv
module tb_multi_req_gen;

  localparam int CHANNELS = 4;
  localparam int KEY_W    = 4;
  localparam int MAX_REQS = 6;
  localparam int CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CHANNELS-1:0] chan_en;
  logic                req;
  logic [KEY_W-1:0]    req_key;
  logic [CH_W-1:0]     req_chan;
  logic                ack;
  logic                busy;
  logic                done;

  int n_cmp  = 0;
  int n_fail = 0;

  multi_req_gen #(.CHANNELS(CHANNELS), .KEY_W(KEY_W), .MAX_REQS(MAX_REQS)) dut (
    .clk(clk), .rst(rst), .start(start), .chan_en(chan_en),
    .req(req), .req_key(req_key), .req_chan(req_chan), .ack(ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is the list of requests it will issue, built
  // round by round over the enabled channels; acks consume it in order.
  int phase = 0;          // 0 idle, 1 issuing, 2 end-of-run
  int exp_q[$];           // chan*256 + key
  int mkey [CHANNELS];

  initial for (int c = 0; c < CHANNELS; c++) mkey[c] = 0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      exp_q.delete();
      for (int c = 0; c < CHANNELS; c++) mkey[c] = 0;
    end else begin
      case (phase)
        0: if (start) begin
          if (chan_en == '0) phase = 2;
          else begin
            for (int r = 0; r < MAX_REQS; r++)
              for (int c = 0; c < CHANNELS; c++)
                if (chan_en[c]) begin
                  exp_q.push_back(c * 256 + mkey[c]);
                  mkey[c] = (mkey[c] + 1) % (1 << KEY_W);
                end
            phase = 1;
          end
        end
        1: if (ack) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    int e_req, e_key, e_chan;
    #1;
    e_req  = (phase == 1) ? 1 : 0;
    e_key  = (e_req != 0) ? exp_q[0] % 256 : 0;
    e_chan = (e_req != 0) ? exp_q[0] / 256 : 0;
    chk("req", int'(req), e_req);
    chk("req_key", int'(req_key), e_key);
    chk("req_chan", int'(req_chan), e_chan);
    chk("busy", int'(busy), (phase != 0) ? 1 : 0);
    chk("done", int'(done), (phase == 2) ? 1 : 0);
  end

  // Log of handshakes actually accepted by the DUT, sampled just before the edge.
  int acc_log[$];
  always @(negedge clk) begin
    #4;
    if (!rst && req && ack) acc_log.push_back(int'(req_chan) * 256 + int'(req_key));
  end

  task automatic run(input logic [CHANNELS-1:0] mask, input int ack_mode,
                     input int start_at, input int rst_after, output int cycles);
    int cyc;
    acc_log.delete();
    chan_en = mask;
    start   = 1'b1;
    ack     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      if (rst_after > 0 && acc_log.size() >= rst_after) begin
        rst = 1'b1;
        ack = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        cycles = cyc;
        return;
      end
      ack   = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      start = (cyc == start_at);
      if (cyc == start_at) chan_en = 4'b1111;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ack   = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
    cycles = cyc;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int k0 [6];
    int k1 [6];
    int k2 [6];
    rst = 1'b1; start = 1'b0; ack = 1'b0; chan_en = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", int'(req), 0);
    chk("rst_key", int'(req_key), 0);
    chk("rst_chan", int'(req_chan), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // Acks while idle must not move any key.
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    @(negedge clk);

    // Single channel, ack held: chan 0 keys 0..5, done after 7 cycles.
    run(4'b0001, 0, -1, 0, cyc);
    chk("single_cycles", cyc, 7);
    chk("single_count", acc_log.size(), 6);
    for (int j = 0; j < 6 && j < acc_log.size(); j++)
      chk("single_seq", acc_log[j], j);
    chk("single_busy_after", int'(busy), 0);

    // Round robin 0,2 with stalls; chan 0 continues at 6, chan 2 starts at 0.
    run(4'b0101, 1, -1, 0, cyc);
    chk("rr_count", acc_log.size(), 12);
    for (int j = 0; j < 12 && j < acc_log.size(); j++)
      chk("rr_seq", acc_log[j], (j % 2 == 0) ? (6 + j / 2) : (2 * 256 + j / 2));

    // Key persistence and wrap on channel 1.
    k0 = '{0, 1, 2, 3, 4, 5};
    k1 = '{6, 7, 8, 9, 10, 11};
    k2 = '{12, 13, 14, 15, 0, 1};
    run(4'b0010, 0, -1, 0, cyc);
    for (int j = 0; j < 6 && j < acc_log.size(); j++) chk("wrap_run1", acc_log[j], 256 + k0[j]);
    run(4'b0010, 0, -1, 0, cyc);
    for (int j = 0; j < 6 && j < acc_log.size(); j++) chk("wrap_run2", acc_log[j], 256 + k1[j]);
    run(4'b0010, 0, -1, 0, cyc);
    chk("wrap_count", acc_log.size(), 6);
    for (int j = 0; j < 6 && j < acc_log.size(); j++) chk("wrap_run3", acc_log[j], 256 + k2[j]);

    // Empty mask: done the very next cycle, no requests.
    run(4'b0000, 0, -1, 0, cyc);
    chk("empty_cycles", cyc, 1);
    chk("empty_count", acc_log.size(), 0);

    // start and a new mask mid-run are ignored.
    run(4'b0101, 0, 3, 0, cyc);
    chk("midstart_count", acc_log.size(), 12);
    chk("midstart_cycles", cyc, 13);

    // Reset after 5 accepts: back to idle, no done, keys cleared.
    run(4'b1111, 0, -1, 5, cyc);
    chk("midrst_count", acc_log.size(), 5);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    run(4'b1111, 0, -1, 0, cyc);
    chk("post_rst_count", acc_log.size(), 24);
    for (int j = 0; j < 4 && j < acc_log.size(); j++)
      chk("post_rst_first", acc_log[j], j * 256);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
